// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request, response and ALU-side signal bundle for alu_share_arbiter.
interface alu_share_arbiter_if #(parameter int DATA_W = 32);
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]        req0_op, req1_op;
    logic              rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero, rsp_err;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic [3:0]        alu_ctrl;
    logic              alu_zero;
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, req1_valid, req1_a, req1_b, req1_op,
        input  rsp0_ready, rsp1_ready, alu_result, alu_zero,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
        output alu_a, alu_b, alu_ctrl
    );
    modport master (
        output req0_valid, req0_a, req0_b, req0_op, req1_valid, req1_a, req1_b, req1_op,
        output rsp0_ready, rsp1_ready, alu_result, alu_zero,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
        input  alu_a, alu_b, alu_ctrl
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external ALU between execute (port 0) and branch unit (port 1).
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input logic                clk,
    input logic                reset,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t            state_q, state_d;
    logic              last_q, last_d, grant_q, grant_d, zero_q, zero_d, err_q, err_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]        op_q, op_d;
    logic              gnt, idle, hs;
    // Tie goes to the port that was not served last; a lone requester always wins.
    assign gnt  = (bus.req0_valid && bus.req1_valid) ? (RR_EN ? ~last_q : 1'b0) : ~bus.req0_valid;
    assign idle = (state_q == IDLE) && !reset;
    assign hs   = grant_q ? bus.rsp1_ready : bus.rsp0_ready;
    assign bus.req0_ready = idle && bus.req0_valid && !gnt;
    assign bus.req1_ready = idle && bus.req1_valid && gnt;
    assign bus.rsp0_valid = (state_q == RESP) && !grant_q;
    assign bus.rsp1_valid = (state_q == RESP) && grant_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_err    = err_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_ctrl   = op_q;
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        zero_d  = zero_q;
        err_d   = err_q;
        if (bus.req0_ready || bus.req1_ready) begin
            grant_d = gnt;
            a_d     = gnt ? bus.req1_a : bus.req0_a;
            b_d     = gnt ? bus.req1_b : bus.req0_b;
            op_d    = gnt ? bus.req1_op : bus.req0_op;
            state_d = EXEC;
        end
        if (state_q == EXEC) begin
            res_d   = bus.alu_result;
            zero_d  = bus.alu_zero;
            err_d   = !(op_q inside {4'b0010, 4'b0110});
            state_d = RESP;
        end
        if (state_q == RESP && hs) begin
            last_d  = grant_q;
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            grant_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end
endmodule
